// File: rtl/pipe_stage_reg.sv
// Elastic pipeline-stage register: main + skid entry under valid/ready, with a
// flush that loads per-field bubble values and a saturating backpressure counter.

module pipe_stage_field #(
  parameter int               WIDTH  = 32,
  parameter logic [WIDTH-1:0] BUBBLE = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_ld_main_in,
  input  logic             i_ld_main_skid,
  input  logic             i_clr_main,
  input  logic             i_ld_skid_in,
  input  logic             i_clr_skid,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_main
);
  logic [WIDTH-1:0] r_main, r_skid;

  // An emptied slot always reverts to the bubble so no stale field leaks out.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_main <= BUBBLE;
      r_skid <= BUBBLE;
    end else begin
      if (i_clr_main)          r_main <= BUBBLE;
      else if (i_ld_main_in)   r_main <= i_data;
      else if (i_ld_main_skid) r_main <= r_skid;

      if (i_clr_skid)          r_skid <= BUBBLE;
      else if (i_ld_skid_in)   r_skid <= i_data;
    end
  end

  assign o_main = r_main;
endmodule

module pipe_stage_reg #(
  parameter int                      WIDTH     = 32,
  parameter int                      FIELDS    = 6,
  parameter logic [FIELDS*WIDTH-1:0] BUBBLE    = {32'h0, 32'h3004, 32'h3008, 32'h0, 32'h0, 32'h0},
  parameter int                      CNT_WIDTH = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_flush,
  input  logic                    i_in_valid,
  output logic                    o_in_ready,
  input  logic [FIELDS*WIDTH-1:0] i_in_data,
  output logic                    o_out_valid,
  input  logic                    i_out_ready,
  output logic [FIELDS*WIDTH-1:0] o_out_data,
  output logic [1:0]              o_occupancy,
  output logic [CNT_WIDTH-1:0]    o_bp_cycles
);
  logic                          r_main_vld, r_skid_vld;
  logic [CNT_WIDTH-1:0]          r_bp;
  logic                          w_accept, w_pop;
  logic                          w_ld_main_in, w_ld_main_skid, w_clr_main, w_ld_skid_in, w_clr_skid;
  logic [FIELDS-1:0][WIDTH-1:0]  w_in, w_main;

  assign w_accept = i_in_valid & ~r_skid_vld;
  assign w_pop    = r_main_vld & i_out_ready;

  always_comb begin
    w_ld_main_in   = 1'b0;
    w_ld_main_skid = 1'b0;
    w_clr_main     = 1'b0;
    w_ld_skid_in   = 1'b0;
    w_clr_skid     = 1'b0;
    if (i_flush) begin
      w_clr_main = 1'b1;
      w_clr_skid = 1'b1;
    end else if (!r_main_vld) begin
      w_ld_main_in = w_accept;
    end else if (w_pop && !r_skid_vld) begin
      w_ld_main_in = w_accept;
      w_clr_main   = ~w_accept;
    end else if (w_pop) begin
      w_ld_main_skid = 1'b1;
      w_clr_skid     = 1'b1;
    end else begin
      w_ld_skid_in = w_accept;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_main_vld <= 1'b0;
      r_skid_vld <= 1'b0;
      r_bp       <= '0;
    end else begin
      r_main_vld <= w_ld_main_in | w_ld_main_skid | (r_main_vld & ~w_clr_main);
      r_skid_vld <= w_ld_skid_in | (r_skid_vld & ~w_clr_skid);
      if (r_main_vld && !i_out_ready && r_bp != '1)
        r_bp <= r_bp + CNT_WIDTH'(1);
    end
  end

  assign w_in = i_in_data;

  for (genvar g = 0; g < FIELDS; g++) begin : g_field
    pipe_stage_field #(
      .WIDTH  (WIDTH),
      .BUBBLE (BUBBLE[g*WIDTH +: WIDTH])
    ) u_field (
      .i_clk          (i_clk),
      .i_rst_n        (i_rst_n),
      .i_ld_main_in   (w_ld_main_in),
      .i_ld_main_skid (w_ld_main_skid),
      .i_clr_main     (w_clr_main),
      .i_ld_skid_in   (w_ld_skid_in),
      .i_clr_skid     (w_clr_skid),
      .i_data         (w_in[g]),
      .o_main         (w_main[g])
    );
  end

  assign o_in_ready  = ~r_skid_vld;
  assign o_out_valid = r_main_vld;
  assign o_out_data  = w_main;
  assign o_occupancy = {1'b0, r_main_vld} + {1'b0, r_skid_vld};
  assign o_bp_cycles = r_bp;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomized scoreboard bench for pipe_stage_reg: a queue of held entries is the
// reference; a negedge monitor compares the head, occupancy and counter.

module tb_pipe_stage_reg;
  localparam int W = 32, F = 6, CW = 4, DW = W*F;
  localparam logic [DW-1:0] BUB = {32'h0, 32'h3004, 32'h3008, 32'h0, 32'h0, 32'h0};
  localparam int BP_MAX = 15;

  logic          clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          o_in_ready, o_out_valid;
  logic [DW-1:0] o_out_data;
  logic [1:0]    o_occ;
  logic [CW-1:0] o_bp;

  logic [DW-1:0] exp_q[$];
  int            bp_exp = 0;
  int            n_tests = 0, n_fail = 0;

  pipe_stage_reg #(.WIDTH(W), .FIELDS(F), .BUBBLE(BUB), .CNT_WIDTH(CW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush),
    .i_in_valid(in_valid), .o_in_ready(o_in_ready), .i_in_data(in_data),
    .o_out_valid(o_out_valid), .i_out_ready(out_ready), .o_out_data(o_out_data),
    .o_occupancy(o_occ), .o_bp_cycles(o_bp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: the model queue holds exactly what the stage should hold now.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("out_valid", DW'(o_out_valid), DW'(exp_q.size() != 0));
      chk("occupancy", DW'(o_occ), DW'(exp_q.size()));
      chk("out_data", o_out_data, (exp_q.size() != 0) ? exp_q[0] : BUB);
      chk("bp_cycles", DW'(o_bp), DW'(bp_exp));
      if (exp_q.size() != 0) begin
        if (out_ready) void'(exp_q.pop_front());
        else if (bp_exp < BP_MAX) bp_exp++;
      end
    end
  end

  // Called just after a rising edge; applies inputs for one cycle.
  task automatic drive(input logic iv, input logic [DW-1:0] d, input logic ordy,
                       input logic fl, output logic acc);
    logic rdy;
    in_valid = iv; in_data = d; out_ready = ordy; flush = fl;
    rdy = (exp_q.size() < 2);
    chk("in_ready", DW'(o_in_ready), DW'(rdy));
    acc = iv & rdy;
    @(posedge clk); #1;
    if (fl) exp_q.delete();
    else if (acc) exp_q.push_back(d);
  endtask

  task automatic idle(input logic ordy, input int n);
    logic acc;
    for (int i = 0; i < n; i++) drive(1'b0, $urandom, ordy, 1'b0, acc);
  endtask

  task automatic push(input logic [DW-1:0] d, input logic ordy);
    logic acc;
    int   tries;
    acc = 1'b0;
    tries = 0;
    while (!acc && tries < 20) begin
      drive(1'b1, d, ordy, 1'b0, acc);
      tries++;
    end
    if (!acc) begin
      n_tests++; n_fail++;
      $display("FAIL push_timeout: got not-accepted expected accepted");
    end
  endtask

  function automatic logic [DW-1:0] rnd();
    logic [DW-1:0] d;
    for (int i = 0; i < F; i++) d[i*W +: W] = $urandom;
    return d;
  endfunction

  function automatic logic [DW-1:0] with_ir(input logic [31:0] ir);
    logic [DW-1:0] d;
    d = rnd();
    d[DW-1 -: W] = ir;
    return d;
  endfunction

  task automatic async_reset_chk();
    in_valid = 1'b0; flush = 1'b0;
    #2 rst_n = 1'b0;
    exp_q.delete();
    bp_exp = 0;
    #1;
    chk("rst_out_valid", DW'(o_out_valid), DW'(1'b0));
    chk("rst_out_data", o_out_data, BUB);
    chk("rst_in_ready", DW'(o_in_ready), DW'(1'b1));
    chk("rst_occupancy", DW'(o_occ), DW'(0));
    chk("rst_bp_cycles", DW'(o_bp), DW'(0));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0]   irs [3];
    logic [DW-1:0] d;
    logic          acc;
    irs[0] = 32'h8C010004; irs[1] = 32'h00221820; irs[2] = 32'h10000003;

    // Reset held for three cycles, then idle
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_data", o_out_data, BUB);
    rst_n = 1'b1;
    d = o_out_data;
    chk("bubble_field1", DW'(d[DW-W-1 -: W]), DW'(32'h3004));
    chk("bubble_field2", DW'(d[DW-2*W-1 -: W]), DW'(32'h3008));
    idle(1'b0, 3);

    // Streaming with downstream always ready
    for (int i = 0; i < 3; i++) push(with_ir(irs[i]), 1'b1);
    idle(1'b1, 2);

    // Backpressure: A, B fill the stage, C waits upstream
    push(with_ir(32'hAAAA0001), 1'b0);
    push(with_ir(32'hBBBB0002), 1'b0);
    d = with_ir(32'hCCCC0003);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, d, 1'b0, 1'b0, acc);
      chk("bp_c_held", DW'(acc), DW'(1'b0));
    end
    push(d, 1'b1);
    idle(1'b1, 3);

    // Flush with full stage and an offered entry
    push(rnd(), 1'b0);
    push(rnd(), 1'b0);
    drive(1'b1, with_ir(32'hDDDD0004), 1'b0, 1'b1, acc);
    idle(1'b1, 3);
    // Flush with one held and an acceptable offer: the offer is discarded
    push(rnd(), 1'b0);
    drive(1'b1, with_ir(32'hDDDD0005), 1'b0, 1'b1, acc);
    idle(1'b1, 2);
    // Flush coincident with a pop
    push(rnd(), 1'b0);
    push(rnd(), 1'b0);
    drive(1'b0, rnd(), 1'b1, 1'b1, acc);
    idle(1'b1, 2);

    // Counter saturation
    push(rnd(), 1'b0);
    idle(1'b0, 20);
    chk("bp_saturated", DW'(o_bp), DW'(BP_MAX));
    idle(1'b1, 2);
    chk("bp_no_clear", DW'(o_bp), DW'(BP_MAX));

    // Asynchronous reset with two entries held
    push(rnd(), 1'b0);
    push(rnd(), 1'b0);
    async_reset_chk();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) push(rnd(), 1'b1);
    idle(1'b1, 2);

    // Randomized traffic
    for (int i = 0; i < 400; i++)
      drive(1'($urandom_range(0, 1)), rnd(), 1'($urandom_range(0, 9) < 7),
            1'($urandom_range(0, 19) == 0), acc);
    idle(1'b1, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
